seq_alu_unit: RTL and testbench

//  Multi-cycle ALU responder for the RISC-V datapath. It accepts one ALU request
//  {opcode, funct, add_rshift_type, A, B} over a valid/ready handshake and returns
//  the 32-bit result over a second valid/ready handshake.

---
 rtl/seq_alu_unit_pkg.sv | 58 +++++
 rtl/alu_func_decode.sv | 32 +++
 rtl/seq_alu_unit.sv | 125 ++++++++++++
 tb/tb_seq_alu_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seq_alu_unit_pkg.sv
// Shared constants for the sequential ALU: RISC-V opcodes, funct3 codes and ALU op encodings.
package seq_alu_unit_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd,
        AluCopyB,
        AluZero
    } alu_op_e;

    // funct3 decode shared by R- and I-type; alt is the already-qualified bit30.
    function automatic alu_op_e arith_op(logic [2:0] funct, logic alt);
        alu_op_e op;
        case (funct)
            F3_ADD:  op = alt ? AluSub : AluAdd;
            F3_SLL:  op = AluSll;
            F3_SLT:  op = AluSlt;
            F3_SLTU: op = AluSltu;
            F3_XOR:  op = AluXor;
            F3_SR:   op = alt ? AluSra : AluSrl;
            F3_OR:   op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    function automatic logic is_shift(alu_op_e op);
        return (op == AluSll) || (op == AluSrl) || (op == AluSra);
    endfunction

endpackage

// File: rtl/alu_func_decode.sv
// Combinational decode of {opcode, funct3, bit30} into an internal ALU operation.
module alu_func_decode
    import seq_alu_unit_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct,
    input  logic       add_rshift_type,
    output logic [3:0] alu_op
);

    alu_op_e op;

    always_comb begin
        op = AluZero;
        case (opcode)
            OPC_LUI:    op = AluCopyB;
            OPC_AUIPC,
            OPC_BRANCH,
            OPC_LOAD,
            OPC_STORE,
            OPC_JAL,
            OPC_JALR:   op = AluAdd;
            OPC_RTYPE:  op = arith_op(funct, add_rshift_type);
            // Immediate forms carry imm bits in 30; only SRAI uses it as a selector.
            OPC_ITYPE:  op = arith_op(funct, add_rshift_type && (funct == F3_SR));
            default:    op = AluZero;
        endcase
    end

    assign alu_op = op;

endmodule

// File: rtl/seq_alu_unit.sv
// Multi-cycle ALU responder: single-cycle ops, bit-serial shifts, valid/ready on both sides.
module seq_alu_unit
    import seq_alu_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct,
    input  logic             add_rshift_type,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] Out
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e             state_q, state_d;
    alu_op_e            op_q, op_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]   out_q, out_d;

    logic [3:0]         dec_op_raw;
    alu_op_e            dec_op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   result;

    alu_func_decode u_decode (
        .opcode          (opcode),
        .funct           (funct),
        .add_rshift_type (add_rshift_type),
        .alu_op          (dec_op_raw)
    );

    assign dec_op = alu_op_e'(dec_op_raw);
    assign shamt  = B[SHAMT_W-1:0];

    // Shifts return A here: a zero shamt completes immediately with A unchanged.
    always_comb begin
        result = '0;
        case (dec_op)
            AluAdd:   result = A + B;
            AluSub:   result = A - B;
            AluSlt:   result = WIDTH'($signed(A) < $signed(B));
            AluSltu:  result = WIDTH'(A < B);
            AluXor:   result = A ^ B;
            AluOr:    result = A | B;
            AluAnd:   result = A & B;
            AluCopyB: result = B;
            AluSll,
            AluSrl,
            AluSra:   result = A;
            default:  result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q;
        out_d   = out_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d = dec_op;
                    if (is_shift(dec_op) && (shamt != '0)) begin
                        out_d   = A;
                        count_d = shamt;
                        state_d = StShift;
                    end else begin
                        out_d   = result;
                        state_d = StDone;
                    end
                end
            end
            StShift: begin
                case (op_q)
                    AluSll:  out_d = {out_q[WIDTH-2:0], 1'b0};
                    AluSrl:  out_d = {1'b0, out_q[WIDTH-1:1]};
                    AluSra:  out_d = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
                    default: out_d = out_q;
                endcase
                count_d = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            op_q    <= AluZero;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StDone);
    assign Out        = out_q;

endmodule

// File: tb/tb_seq_alu_unit.sv
// Directed self-checking bench for seq_alu_unit with hand-computed results and latencies.
module tb_seq_alu_unit;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] BADOPC = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct;
    logic        add_rshift_type;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] out;

    int n_cmp = 0;
    int n_err = 0;

    seq_alu_unit dut (
        .Clock           (clk),
        .Reset           (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .opcode          (opcode),
        .funct           (funct),
        .add_rshift_type (add_rshift_type),
        .A               (a_in),
        .B               (b_in),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .Out             (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request at the falling edge; returns just after the accepting edge.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f, input logic b30,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        opcode = opc; funct = f; add_rshift_type = b30; a_in = a; b_in = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Counts rising edges after the accept edge until resp_valid is seen.
    task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f,
                          input logic b30, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_edges);
        int edges;
        issue(opc, f, b30, a, b);
        edges = 0;
        while (!resp_valid && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_lat"}, edges, exp_edges);
        check({tag, "_out"}, out, exp);
    endtask

    task automatic release_resp(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, "_rv_low"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_rdy_high"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; resp_ready = 1'b0;
        opcode = '0; funct = '0; add_rshift_type = 1'b0; a_in = '0; b_in = '0;
        #12;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_out", out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add", RTYPE, 3'b000, 1'b0, 32'hfd504144, 32'h5bfeca86, 32'h594f0bca, 0);
        release_resp("add");
        run_op("lui", LUI, 3'b110, 1'b1, 32'h0badf00d, 32'h12345000, 32'h12345000, 0);
        release_resp("lui");
        run_op("sra4", RTYPE, 3'b101, 1'b1, 32'h80000000, 32'h00000004, 32'hf8000000, 4);
        release_resp("sra4");
        run_op("sll31", RTYPE, 3'b001, 1'b0, 32'h00000001, 32'h0000001f, 32'h80000000, 31);
        release_resp("sll31");
        run_op("srl0", RTYPE, 3'b101, 1'b0, 32'hdeadbeef, 32'h00000020, 32'hdeadbeef, 0);
        release_resp("srl0");
        run_op("sub", RTYPE, 3'b000, 1'b1, 32'd5, 32'd7, 32'hfffffffe, 0);
        release_resp("sub");
        run_op("slt", RTYPE, 3'b010, 1'b0, 32'hffffffff, 32'd1, 32'd1, 0);
        release_resp("slt");
        run_op("sltu", RTYPE, 3'b011, 1'b0, 32'hffffffff, 32'd1, 32'd0, 0);
        release_resp("sltu");
        run_op("xor", RTYPE, 3'b100, 1'b0, 32'ha5a5a5a5, 32'hffff0000, 32'h5a5aa5a5, 0);
        release_resp("xor");
        run_op("addi_b30", ITYPE, 3'b000, 1'b1, 32'd16, 32'd32, 32'd48, 0);
        release_resp("addi_b30");
        run_op("srai1", ITYPE, 3'b101, 1'b1, 32'h80000000, 32'h00000401, 32'hc0000000, 1);
        release_resp("srai1");
        run_op("srli2", ITYPE, 3'b101, 1'b0, 32'h80000000, 32'h00000002, 32'h20000000, 2);
        release_resp("srli2");
        run_op("jal", JAL, 3'b010, 1'b1, 32'h00001000, 32'hfffffffc, 32'h00000ffc, 0);
        release_resp("jal");
        run_op("badopc", BADOPC, 3'b000, 1'b0, 32'h11111111, 32'h22222222, 32'd0, 0);
        release_resp("badopc");

        // Backpressure: result and flags hold while a competing request is ignored.
        run_op("bp", RTYPE, 3'b110, 1'b0, 32'hf0f00000, 32'h0000000f, 32'hf0f0000f, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            opcode = LUI; b_in = 32'hcafef00d; req_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_out_hold", out, 32'hf0f0000f);
            check("bp_rv_hold", {31'b0, resp_valid}, 32'd1);
            check("bp_rdy_low", {31'b0, req_ready}, 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        release_resp("bp");

        // Asynchronous reset mid-shift aborts with no response.
        issue(RTYPE, 3'b001, 1'b0, 32'h00000001, 32'h00000014);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_rv", {31'b0, resp_valid}, 32'd0);
        check("arst_rdy", {31'b0, req_ready}, 32'd1);
        check("arst_out", out, 32'd0);
        #1;
        rst = 1'b0;
        run_op("post_rst_add", RTYPE, 3'b000, 1'b0, 32'd2, 32'd3, 32'd5, 0);
        release_resp("post_rst_add");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
